// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first, rep times, then pulses done.
// Define PATTERN_TX_GAP_EN to insert one zero-valued valid cycle between repetitions.
module pattern_tx #(
    parameter int                   PAT_WIDTH = 5,
    parameter logic [PAT_WIDTH-1:0] PATTERN   = 5'b11011,
    parameter int                   CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] rep,
    input  logic                 abort,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int                 IDX_W    = $clog2(PAT_WIDTH);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(PAT_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
`ifdef PATTERN_TX_GAP_EN
        GAP  = 2'd3,
`endif
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   bit_out_q, bit_valid_q, busy_q, done_q;
    logic                   emitting_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // abort outranks start even though abort alone does nothing here
                if (start && !abort) begin
                    if (rep != '0) begin
                        state_d = SEND;
                        idx_d   = IDX_LAST;
                        cnt_d   = rep;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = IDX_LAST;
`ifdef PATTERN_TX_GAP_EN
                        state_d = GAP;
`else
                        state_d = SEND;
`endif
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
`ifdef PATTERN_TX_GAP_EN
            GAP: begin
                state_d = abort ? IDLE : SEND;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef PATTERN_TX_GAP_EN
    assign emitting_d = (state_d == SEND) || (state_d == GAP);
`else
    assign emitting_d = (state_d == SEND);
`endif

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            bit_out_q   <= (state_d == SEND) ? PATTERN[idx_d] : 1'b0;
            bit_valid_q <= emitting_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: directed scenarios plus randomized transactions
// checked against a stream model built from the repetition/gap rules.
module tb_pattern_tx;

    localparam int PW = 5;
    localparam int CW = 4;
`ifdef PATTERN_TX_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [CW-1:0] rep;
    logic          bit_out, bit_valid, busy, done;

    int            vectors = 0;
    int            miscompares = 0;
    logic [PW-1:0] patBits = 5'b11011;
    bit            obsBits[$];

    always #5 clk = ~clk;

    pattern_tx #(.PAT_WIDTH(PW), .PATTERN(5'b11011), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .rep(rep), .abort(abort),
        .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy), .done(done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int streamLen(input int r);
        return r * PW + ((GAP_EN && r > 0) ? r - 1 : 0);
    endfunction

    // Start a transaction in cycle 0, then compare every cycle against the model stream.
    // abortAt/rstAt/restartAt give the cycle the event is driven in (0 = never).
    task automatic applyStimulus(input int repVal, input int abortAt, input int rstAt,
                                 input int restartAt, input string tag);
        bit expBits[$];
        int L, cut;
        bit live;
        expBits = {};
        for (int r = 0; r < repVal; r++) begin
            if (GAP_EN && r > 0) expBits.push_back(1'b0);
            for (int i = PW - 1; i >= 0; i--) expBits.push_back(patBits[i]);
        end
        L   = expBits.size();
        cut = 1 << 30;
        if (abortAt > 0) cut = abortAt;
        if (rstAt > 0 && rstAt < cut) cut = rstAt;
        obsBits = {};
        start = 1'b1; rep = CW'(repVal); abort = 1'b0; rst = 1'b0;
        tick;
        start = 1'b0; rep = CW'($urandom);
        for (int c = 1; c <= L + 3; c++) begin
            live = (c <= cut);
            checkOutput($sformatf("%s c%0d valid", tag, c), int'(bit_valid), int'(live && c <= L));
            if (live && c <= L)
                checkOutput($sformatf("%s c%0d bit", tag, c), int'(bit_out), int'(expBits[c-1]));
            else
                checkOutput($sformatf("%s c%0d bit", tag, c), int'(bit_out), 0);
            checkOutput($sformatf("%s c%0d done", tag, c), int'(done), int'(live && c == L + 1));
            checkOutput($sformatf("%s c%0d busy", tag, c), int'(busy), int'(live && c <= L + 1));
            if (bit_valid) obsBits.push_back(bit_out);
            abort = (c == abortAt);
            rst   = (c == rstAt);
            start = (c == restartAt);
            if (start) rep = CW'($urandom);
            tick;
        end
        abort = 1'b0; rst = 1'b0; start = 1'b0;
    endtask

    initial begin
        int repVal, mode, L, hits;
        logic [15:0] got;
        logic [4:0]  win;
        $display("[TB] pattern_tx bench, gap=%0d", GAP_EN);
        rst = 1'b1; start = 1'b1; abort = 1'b0; rep = 4'd3;
        tick;
        tick;
        checkOutput("reset valid", int'(bit_valid), 0);
        checkOutput("reset bit",   int'(bit_out), 0);
        checkOutput("reset busy",  int'(busy), 0);
        checkOutput("reset done",  int'(done), 0);
        rst = 1'b0; start = 1'b0;
        tick;
        checkOutput("idle busy", int'(busy), 0);

        applyStimulus(1, 0, 0, 0, "rep1");

`ifdef PATTERN_TX_GAP_EN
        applyStimulus(2, 0, 0, 0, "gap2");
        got = '0;
        foreach (obsBits[i]) got = {got[14:0], obsBits[i]};
        checkOutput("gap2 len", obsBits.size(), 11);
        checkOutput("gap2 stream", int'(got), int'(16'b0000011011011011));
`else
        applyStimulus(3, 0, 0, 0, "rep3");
        got = '0; win = '0; hits = 0;
        foreach (obsBits[i]) begin
            got = {got[14:0], obsBits[i]};
            win = {win[3:0], obsBits[i]};
            if (i >= 4 && win == 5'b11011) hits++;
        end
        checkOutput("rep3 len", obsBits.size(), 15);
        checkOutput("rep3 stream", int'(got), int'(16'b0110111101111011));
        checkOutput("rep3 detections", hits, 3);
`endif

        applyStimulus(0, 0, 0, 0, "rep0");
        applyStimulus(2, 3, 0, 0, "abort3");
        applyStimulus(2, 0, 0, 2, "restart");
        applyStimulus(2, 0, 2, 0, "rstmid");
        applyStimulus(1, 6, 0, 0, "abortDone");

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1; rep = 4'd3;
        tick;
        start = 1'b0; abort = 1'b0;
        checkOutput("abortIdle busy",  int'(busy), 0);
        checkOutput("abortIdle valid", int'(bit_valid), 0);
        tick;
        checkOutput("abortIdle busy2", int'(busy), 0);
        checkOutput("abortIdle done",  int'(done), 0);

        for (int t = 0; t < 25; t++) begin
            repVal = $urandom_range(0, 15);
            mode   = $urandom_range(0, 3);
            L      = streamLen(repVal);
            case (mode)
                1:       applyStimulus(repVal, $urandom_range(1, L + 1), 0, 0, $sformatf("rnd%0d", t));
                2:       applyStimulus(repVal, 0, $urandom_range(1, L + 1), 0, $sformatf("rnd%0d", t));
                3:       applyStimulus(repVal, 0, 0, $urandom_range(1, L + 1), $sformatf("rnd%0d", t));
                default: applyStimulus(repVal, 0, 0, 0, $sformatf("rnd%0d", t));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
